wb_bus_decoder: RTL and testbench
=================================

// Module: wb_bus_decoder
// PURPOSE
//  Pipelined Wishbone B4 router: one master (cpu) to NSLAVES slaves (mem, uart, timer...). Replaces point-to-point cpu<->mem wiring.
//  Decodes the address to one slave and tracks outstanding transactions. Returns registered ack/err/data.
//  Signals ERR for unmapped addresses and for slaves that never answer (timeout).
// PARAMETERS
//  NSLAVES     2              number of slave ports (1..8)
//  AW          32             address width
//  DW          32             data width; select width SW = DW/8
//  SLAVE_BASE  {32'h1000_0000,32'h0}  packed NSLAVES*AW base addresses, slave 0 in LSBs
//  SLAVE_MASK  {32'hF000_0000,32'hF000_0000}  packed NSLAVES*AW masks; hit = (addr & mask) == base
//  MAX_OUTST   4              max in-flight requests (power of 2, >=1)
//  TIMEOUT     255            idle cycles with requests pending before abort (>=2)
// PORTS
//  i_clk        in   1          clock, all logic on rising edge
//  i_reset_n    in   1          asynchronous, active-low reset
//  i_wb_cyc     in   1          master cycle
//  i_wb_stb     in   1          master strobe
//  i_wb_we      in   1          master write enable
//  i_wb_addr    in   AW         master address
//  i_wb_data    in   DW         master write data
//  i_wb_sel     in   SW         master byte selects
//  o_wb_stall   out  1          stall to master
//  o_wb_ack     out  1          registered ack to master
//  o_wb_err     out  1          registered error to master
//  o_wb_data    out  DW         registered read data
//  o_s_cyc      out  NSLAVES    per-slave cycle
//  o_s_stb      out  NSLAVES    per-slave strobe
//  o_s_we/o_s_addr/o_s_data/o_s_sel  out  1/AW/DW/SW  broadcast to all slaves
//  i_s_stall    in   NSLAVES    per-slave stall
//  i_s_ack      in   NSLAVES    per-slave ack
//  i_s_err      in   NSLAVES    per-slave error
//  i_s_data     in   NSLAVES*DW packed read data, slave 0 in LSBs
// BEHAVIOUR
//  Reset values: o_wb_ack=0, o_wb_err=0, o_wb_data=0. Internally: cur_slv=0, outst=0, tmo_cnt=0, state=IDLE.
//   o_s_cyc/o_s_stb/o_wb_stall are combinational and reset to 0.
//  Decode: lowest-index hit wins. No hit selects internal null slave NULL.
//  Request path is combinational: o_s_stb[k] = i_wb_stb & hit[k] & ~block. This adds 0 cycles.
//   o_s_cyc[k] = i_wb_cyc & (state==BUSY ? cur_slv==k : hit[k]).
//  block = (outst==MAX_OUTST) | (outst!=0 & dest!=cur_slv) | (state==ABORT).
//   o_wb_stall = block | (dest!=NULL & i_s_stall[dest]).
//  A request is accepted when stb & ~o_wb_stall. The accept latches cur_slv=dest and increments outst.
//  Response is registered and adds 1 cycle. A slave ack/err from cur_slv while outst>0 gives next cycle
//   o_wb_ack/o_wb_err=1, o_wb_data=i_s_data[cur_slv], and decrements outst.
//   ack and err in the same cycle: err wins. Responses while outst==0 or from other slaves are dropped.
//  NULL slave: each accepted request produces o_wb_err exactly 1 cycle later. Never stalls.
//  Accept and response in the same cycle: outst unchanged.
//  FSM: IDLE (outst==0) -> BUSY on accept.
//   BUSY -> IDLE when outst reaches 0.
//   BUSY -> ABORT when tmo_cnt==TIMEOUT.
//   ABORT lasts 1 cycle -> IDLE.
//  tmo_cnt: cleared on any accept/response/IDLE, else +1 in BUSY. Saturates.
//  ABORT: o_s_cyc=0 for that cycle (slave-side abort). o_wb_err=1 next cycle, single pulse regardless of outst.
//   outst and cur_slv are cleared.
//  i_wb_cyc low at any time: outst, tmo_cnt and state are cleared next edge. Late acks are ignored. No ack/err issued.
//  Async reset mid-transfer: everything returns to the reset values immediately. No output glitch after release.
// STRUCTURE
//  Shared package wb_pkg: WB_DW, WB_AW, WB_SW, the address-map constants (MEM_BASE, MEM_MASK...), and a localparam for the NULL slave index.
//  One sub-module: wb_addr_match (combinational, parametrised base/mask, emits hit vector + encoded dest).
//  Outstanding counter, FSM, timeout and response register stay in this module.
// TESTING
//  1. Single read to 0x0000_0010; slave0 acks 2 cycles later with 0xDEADBEEF -> o_wb_ack 1 cycle after slave ack, o_wb_data=0xDEADBEEF, outst back to 0.
//  2. MAX_OUTST=4 back-to-back stb to slave0 with slave acks withheld -> 4 accepts, 5th stalled. Release acks -> 4 acks in order, outst 0.
//  3. Access slave0 then immediately slave1 (0x1000_0000) -> slave1 stb held by stall until slave0 ack. Then accepted; no reordering.
//  4. Read 0x8000_0000 (unmapped) -> no o_s_stb; o_wb_err pulses 1 cycle after accept.
//  5. Slave1 never acks, TIMEOUT=16 -> o_s_cyc[1] drops for 1 cycle at count 16; one o_wb_err pulse; a late ack afterwards is dropped.
//  6. i_reset_n low while 2 requests pending -> outputs 0 asynchronously. After release a fresh read completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone bus definitions: bus widths, default address map, null-slave index
// and the router FSM state type.
package wb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = WB_DW / 8;

    // Default address map: memory at 0x0xxx_xxxx, uart at 0x1xxx_xxxx
    localparam logic [WB_AW-1:0] MEM_BASE  = 32'h0000_0000;
    localparam logic [WB_AW-1:0] MEM_MASK  = 32'hF000_0000;
    localparam logic [WB_AW-1:0] UART_BASE = 32'h1000_0000;
    localparam logic [WB_AW-1:0] UART_MASK = 32'hF000_0000;

    // Slave index width covers up to 8 real slaves plus the null slave
    localparam int unsigned      SLV_W    = 4;
    localparam logic [SLV_W-1:0] NULL_SLV = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAbort
    } state_e;

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address decoder: priority-resolved one-hot hit vector and encoded
// destination index. Lowest-index match wins; no match yields NULL_SLV.
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int unsigned           NSLAVES    = 2,
    parameter int unsigned           AW         = WB_AW,
    parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = {UART_BASE, MEM_BASE},
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = {UART_MASK, MEM_MASK}
) (
    input  logic [AW-1:0]      addr,
    output logic [NSLAVES-1:0] hit,
    output logic [SLV_W-1:0]   dest
);

    logic [NSLAVES-1:0] raw_hit;

    // Raw compare per slave, then keep only the lowest set bit and encode it
    always_comb begin
        for (int k = 0; k < int'(NSLAVES); k++) begin
            raw_hit[k] = (addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW];
        end
        hit  = raw_hit & (~raw_hit + NSLAVES'(1));
        dest = NULL_SLV;
        for (int k = int'(NSLAVES) - 1; k >= 0; k--) begin
            if (raw_hit[k]) begin
                dest = SLV_W'(k);
            end
        end
    end

endmodule

// File: rtl/wb_bus_decoder.sv
// Pipelined Wishbone B4 router, one master to NSLAVES slaves. Requests pass through
// combinationally; responses are registered. Unmapped addresses and silent slaves
// are answered with an error.
module wb_bus_decoder
    import wb_pkg::*;
#(
    parameter int unsigned           NSLAVES    = 2,
    parameter int unsigned           AW         = WB_AW,
    parameter int unsigned           DW         = WB_DW,
    parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = {UART_BASE, MEM_BASE},
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = {UART_MASK, MEM_MASK},
    parameter int unsigned           MAX_OUTST  = 4,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [AW-1:0]         i_wb_addr,
    input  logic [DW-1:0]         i_wb_data,
    input  logic [DW/8-1:0]       i_wb_sel,
    output logic                  o_wb_stall,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic [DW-1:0]         o_wb_data,
    output logic [NSLAVES-1:0]    o_s_cyc,
    output logic [NSLAVES-1:0]    o_s_stb,
    output logic                  o_s_we,
    output logic [AW-1:0]         o_s_addr,
    output logic [DW-1:0]         o_s_data,
    output logic [DW/8-1:0]       o_s_sel,
    input  logic [NSLAVES-1:0]    i_s_stall,
    input  logic [NSLAVES-1:0]    i_s_ack,
    input  logic [NSLAVES-1:0]    i_s_err,
    input  logic [NSLAVES*DW-1:0] i_s_data
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic [OW-1:0]    outst_q;
    logic [TW-1:0]    tmo_cnt_q;
    logic [SLV_W-1:0] cur_slv_q;
    logic             ack_q;
    logic             err_q;
    logic [DW-1:0]    data_q;

    logic [NSLAVES-1:0] hit;
    logic [SLV_W-1:0]   dest;
    logic               dest_stall;
    logic               cur_ack;
    logic               cur_err;
    logic [DW-1:0]      cur_data;
    logic               block;
    logic               stall;
    logic               accept;
    logic               real_accept;
    logic               null_accept;
    logic               resp;
    logic [OW-1:0]      outst_nxt;

    wb_addr_match #(
        .NSLAVES    (NSLAVES),
        .AW         (AW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_addr_match (
        .addr (i_wb_addr),
        .hit  (hit),
        .dest (dest)
    );

    // Request-side decode: stall, accept, and the response coming back from cur_slv
    always_comb begin
        dest_stall = 1'b0;
        cur_ack    = 1'b0;
        cur_err    = 1'b0;
        cur_data   = '0;
        for (int k = 0; k < int'(NSLAVES); k++) begin
            if (dest == SLV_W'(k)) begin
                dest_stall = i_s_stall[k];
            end
            if (cur_slv_q == SLV_W'(k)) begin
                cur_ack  = i_s_ack[k];
                cur_err  = i_s_err[k];
                cur_data = i_s_data[k*DW +: DW];
            end
        end
        // Only one slave may have requests in flight, so switching waits for drain
        block = (outst_q == OW'(MAX_OUTST))
              | ((outst_q != '0) & (dest != cur_slv_q))
              | (state_q == StAbort);
        stall       = block | dest_stall;
        accept      = i_wb_cyc & i_wb_stb & ~stall;
        null_accept = accept & (dest == NULL_SLV);
        real_accept = accept & (dest != NULL_SLV);
        resp        = (state_q != StAbort) & (outst_q != '0) & (cur_ack | cur_err);
        outst_nxt   = outst_q;
        if (real_accept && !resp) begin
            outst_nxt = outst_q + OW'(1);
        end else if (!real_accept && resp) begin
            outst_nxt = outst_q - OW'(1);
        end
    end

    // Slave-facing handshake; forced low while reset is asserted
    always_comb begin
        o_wb_stall = i_reset_n & stall;
        o_s_stb    = (i_reset_n & i_wb_stb & ~block) ? hit : '0;
        for (int k = 0; k < int'(NSLAVES); k++) begin
            if (state_q == StBusy) begin
                o_s_cyc[k] = (cur_slv_q == SLV_W'(k));
            end else begin
                o_s_cyc[k] = hit[k];
            end
        end
        if (!i_reset_n || !i_wb_cyc || state_q == StAbort) begin
            o_s_cyc = '0;
        end
    end

    assign o_s_we    = i_wb_we;
    assign o_s_addr  = i_wb_addr;
    assign o_s_data  = i_wb_data;
    assign o_s_sel   = i_wb_sel;
    assign o_wb_ack  = ack_q;
    assign o_wb_err  = err_q;
    assign o_wb_data = data_q;

    // FSM, outstanding counter, timeout counter and registered response
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            outst_q   <= '0;
            tmo_cnt_q <= '0;
            cur_slv_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (!i_wb_cyc) begin
                // Master abandoned the cycle: forget everything in flight
                state_q   <= StIdle;
                outst_q   <= '0;
                tmo_cnt_q <= '0;
            end else if (state_q == StAbort) begin
                err_q     <= 1'b1;
                outst_q   <= '0;
                cur_slv_q <= '0;
                tmo_cnt_q <= '0;
                state_q   <= StIdle;
            end else begin
                if (accept) begin
                    cur_slv_q <= dest;
                end
                // Null slave answers at once; it never coincides with a real response
                if (null_accept) begin
                    err_q <= 1'b1;
                end else if (resp) begin
                    err_q  <= cur_err;
                    ack_q  <= cur_ack & ~cur_err;
                    data_q <= cur_data;
                end
                outst_q <= outst_nxt;
                if (accept || resp || state_q == StIdle) begin
                    tmo_cnt_q <= '0;
                end else if (tmo_cnt_q != TW'(TIMEOUT)) begin
                    tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
                if (state_q == StBusy && !accept && !resp && tmo_cnt_q == TW'(TIMEOUT)) begin
                    state_q <= StAbort;
                end else if (outst_nxt == '0) begin
                    state_q <= StIdle;
                end else begin
                    state_q <= StBusy;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder: reset, single read, pipelining limit, slave
// switch ordering, unmapped access, timeout abort and mid-transfer reset.
module tb_wb_bus_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata;
    logic [1:0]  s_cyc;
    logic [1:0]  s_stb;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_sel;
    logic [1:0]  s_stall;
    logic [1:0]  s_ack;
    logic [1:0]  s_err;
    logic [63:0] s_rdata;

    int checks = 0;
    int errors = 0;

    wb_bus_decoder #(
        .TIMEOUT (16)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_stall (stall_o),
        .o_wb_ack   (ack_o),
        .o_wb_err   (err_o),
        .o_wb_data  (rdata),
        .o_s_cyc    (s_cyc),
        .o_s_stb    (s_stb),
        .o_s_we     (s_we),
        .o_s_addr   (s_addr),
        .o_s_data   (s_wdata),
        .o_s_sel    (s_sel),
        .i_s_stall  (s_stall),
        .i_s_ack    (s_ack),
        .i_s_err    (s_err),
        .i_s_data   (s_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = 32'h1234_5678;
        sel     = 4'hF;
        s_stall = '0;
        s_ack   = '0;
        s_err   = '0;
        s_rdata = '0;
        tick();
        tick();
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", rdata, 0);
        check("rst_stall", stall_o, 0);
        check("rst_scyc", s_cyc, 0);
        check("rst_sstb", s_stb, 0);
        rst_n = 1'b1;
        tick();

        // 1: single read to slave 0, acked two cycles after accept
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h0000_0010;
        #1;
        check("t1_sstb", s_stb, 2'b01);
        check("t1_scyc", s_cyc, 2'b01);
        check("t1_stall", stall_o, 0);
        check("t1_bcast_addr", s_addr, 32'h0000_0010);
        check("t1_bcast_data", s_wdata, 32'h1234_5678);
        tick();
        stb = 1'b0;
        check("t1_outst1", dut.outst_q, 1);
        check("t1_noack0", ack_o, 0);
        tick();
        s_ack   = 2'b01;
        s_rdata = 64'h0000_0000_DEAD_BEEF;
        check("t1_noack1", ack_o, 0);
        tick();
        s_ack = 2'b00;
        check("t1_ack", ack_o, 1);
        check("t1_data", rdata, 32'hDEAD_BEEF);
        check("t1_outst0", dut.outst_q, 0);
        tick();
        check("t1_ack_drop", ack_o, 0);
        cyc = 1'b0;
        tick();

        // 2: four back-to-back accepts, fifth stalls, acks return in order
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h0000_0020;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_accept_nostall", stall_o, 0);
            tick();
        end
        #1;
        check("t2_full_stall", stall_o, 1);
        check("t2_full_sstb", s_stb, 2'b00);
        check("t2_outst4", dut.outst_q, 4);
        tick();
        check("t2_fifth_held", dut.outst_q, 4);
        stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_ack   = 2'b01;
            s_rdata = {32'h0, 32'(256 + i)};
            tick();
            check("t2_ack", ack_o, 1);
            check("t2_data", rdata, 32'(256 + i));
        end
        s_ack = 2'b00;
        check("t2_outst0", dut.outst_q, 0);
        tick();
        check("t2_ack_drop", ack_o, 0);
        cyc = 1'b0;
        tick();

        // 3: slave 0 then slave 1; slave 1 waits until slave 0 drains
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h0000_0040;
        #1;
        check("t3_s0_sstb", s_stb, 2'b01);
        tick();
        addr = 32'h1000_0000;
        #1;
        check("t3_s1_stall", stall_o, 1);
        check("t3_s1_nostb", s_stb, 2'b00);
        check("t3_busy_cyc", s_cyc, 2'b01);
        tick();
        check("t3_s1_held", dut.outst_q, 1);
        s_ack   = 2'b01;
        s_rdata = {32'h0, 32'h11};
        tick();
        s_ack = 2'b00;
        check("t3_s0_ack", ack_o, 1);
        check("t3_s0_data", rdata, 32'h11);
        #1;
        check("t3_s1_free", stall_o, 0);
        check("t3_s1_sstb", s_stb, 2'b10);
        check("t3_s1_scyc", s_cyc, 2'b10);
        tick();
        stb = 1'b0;
        check("t3_s1_noack", ack_o, 0);
        check("t3_s1_outst", dut.outst_q, 1);
        s_ack   = 2'b10;
        s_rdata = {32'h22, 32'h0};
        tick();
        s_ack = 2'b00;
        check("t3_s1_ack", ack_o, 1);
        check("t3_s1_data", rdata, 32'h22);
        cyc = 1'b0;
        tick();

        // 4: unmapped address answered by the null slave
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h8000_0000;
        #1;
        check("t4_nostb", s_stb, 2'b00);
        check("t4_nocyc", s_cyc, 2'b00);
        check("t4_nostall", stall_o, 0);
        tick();
        stb = 1'b0;
        check("t4_err", err_o, 1);
        check("t4_noack", ack_o, 0);
        check("t4_outst", dut.outst_q, 0);
        tick();
        check("t4_err_drop", err_o, 0);
        cyc = 1'b0;
        tick();

        // 5: slave 1 never answers; abort after 16 idle cycles
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h1000_0004;
        tick();
        stb = 1'b0;
        check("t5_outst", dut.outst_q, 1);
        repeat (16) tick();
        check("t5_cyc_before", s_cyc, 2'b10);
        check("t5_noerr_before", err_o, 0);
        tick();
        check("t5_abort_cyc", s_cyc, 2'b00);
        check("t5_abort_noerr", err_o, 0);
        tick();
        check("t5_err", err_o, 1);
        check("t5_cyc_back", s_cyc, 2'b10);
        check("t5_outst_clr", dut.outst_q, 0);
        s_ack   = 2'b10;
        s_rdata = {32'h77, 32'h0};
        tick();
        s_ack = 2'b00;
        check("t5_late_noack", ack_o, 0);
        check("t5_err_single", err_o, 0);
        cyc = 1'b0;
        tick();

        // 6: asynchronous reset with requests pending, then a fresh read
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 32'h0000_0010;
        tick();
        tick();
        stb = 1'b0;
        check("t6_outst2", dut.outst_q, 2);
        s_ack   = 2'b01;
        s_rdata = {32'h0, 32'h55};
        tick();
        s_ack = 2'b00;
        check("t6_pre_ack", ack_o, 1);
        check("t6_pre_data", rdata, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack", ack_o, 0);
        check("t6_rst_data", rdata, 0);
        check("t6_rst_err", err_o, 0);
        check("t6_rst_scyc", s_cyc, 2'b00);
        check("t6_rst_outst", dut.outst_q, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_rel_ack", ack_o, 0);
        check("t6_rel_err", err_o, 0);
        stb = 1'b1;
        tick();
        stb = 1'b0;
        check("t6_new_outst", dut.outst_q, 1);
        s_ack   = 2'b01;
        s_rdata = {32'h0, 32'hCAFE_F00D};
        tick();
        s_ack = 2'b00;
        check("t6_new_ack", ack_o, 1);
        check("t6_new_data", rdata, 32'hCAFE_F00D);
        tick();
        check("t6_new_ack_drop", ack_o, 0);
        check("t6_new_outst0", dut.outst_q, 0);
        cyc = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
